weighted_round_robin_arbiter: RTL



---
 rtl/weighted_round_robin_arbiter.sv | 97 +++++++++
 1 files changed

// File: rtl/weighted_round_robin_arbiter.sv
// Weighted round-robin arbiter: holds a one-hot grant for up to weight+1 transfers (WRR_ARBITER_LAST_EN adds early release on last).
// Latency: grant registered one cycle after request from IDLE; back-to-back rotation on release.
// Backpressure: grant_ready=0 stalls with grant and credit held; a request drop releases immediately.
module weighted_round_robin_arbiter #(
   parameter int WORD_WIDTH   = 4,
   parameter int WEIGHT_WIDTH = 4
) (
   input  logic                               clock,
   input  logic                               reset_n,
   input  logic [WORD_WIDTH-1:0]              requests,
   input  logic [WORD_WIDTH*WEIGHT_WIDTH-1:0] weights,
   input  logic                               grant_ready,
`ifdef WRR_ARBITER_LAST_EN
   input  logic                               last,
`endif
   output logic [WORD_WIDTH-1:0]              grant,
   output logic                               grant_valid
);

   typedef enum logic {IDLE, HOLD} state_t;

   localparam logic [WORD_WIDTH-1:0]   REQ_ONE    = WORD_WIDTH'(1);
   localparam logic [WORD_WIDTH-1:0]   REQ_MSB    = REQ_ONE << (WORD_WIDTH - 1);
   localparam logic [WEIGHT_WIDTH:0]   CREDIT_ONE = (WEIGHT_WIDTH + 1)'(1);

   state_t                  state;
   logic [WORD_WIDTH-1:0]   last_grant;
   logic [WEIGHT_WIDTH:0]   credit;

   logic [WORD_WIDTH-1:0]   above_mask;
   logic [WORD_WIDTH-1:0]   masked_req;
   logic [WORD_WIDTH-1:0]   winner;
   logic [WEIGHT_WIDTH-1:0] winner_weight;
   logic [WEIGHT_WIDTH:0]   winner_credit;
   logic                    xfer;
   logic                    last_xfer;
   logic                    release_grant;
   logic                    load_winner;
   logic                    go_idle;

   // Bits strictly above the one-hot last_grant; lowest-set-bit isolation via x & -x.
   always_comb begin
      above_mask = ~(last_grant | (last_grant - REQ_ONE));
      masked_req = requests & above_mask;
      if (masked_req != '0) begin
         winner = masked_req & (~masked_req + REQ_ONE);
      end else begin
         winner = requests & (~requests + REQ_ONE);
      end
   end

   always_comb begin
      winner_weight = '0;
      for (int i = 0; i < WORD_WIDTH; i++) begin
         if (winner[i]) begin
            winner_weight = weights[i*WEIGHT_WIDTH +: WEIGHT_WIDTH];
         end
      end
      winner_credit = {1'b0, winner_weight} + CREDIT_ONE;
   end

   always_comb begin
      xfer = grant_valid & grant_ready;
`ifdef WRR_ARBITER_LAST_EN
      last_xfer = xfer & last;
`else
      last_xfer = 1'b0;
`endif
      release_grant = (xfer && (credit == CREDIT_ONE)) || ((requests & grant) == '0) || last_xfer;
      load_winner   = (|requests) && ((state == IDLE) || release_grant);
      go_idle       = (state == HOLD) && release_grant && !(|requests);
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         grant       <= '0;
         grant_valid <= 1'b0;
         credit      <= '0;
         last_grant  <= REQ_MSB;
      end else if (load_winner) begin
         state       <= HOLD;
         grant       <= winner;
         grant_valid <= 1'b1;
         last_grant  <= winner;
         credit      <= winner_credit;
      end else if (go_idle) begin
         state       <= IDLE;
         grant       <= '0;
         grant_valid <= 1'b0;
         credit      <= '0;
      end else if ((state == HOLD) && xfer) begin
         credit      <= credit - CREDIT_ONE;
      end
   end

endmodule
